// File: rtl/sipo_deframer.sv
// Serial-in deframer: start bit, then WIDTH data bits MSB-first, into a one-word valid/ready holding register.
// Optional even-parity bit after the data bits when SIPO_DEFRAMER_PARITY_EN is defined.
module sipo_deframer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             serial_in,
  input  logic             shift_en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overrun
`ifdef SIPO_DEFRAMER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_DEFRAMER_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t           state, nxt;
  logic [WIDTH-1:0] shift_reg, word;
  logic [CW-1:0]    cnt;
  logic             done, perr_now;
  logic             accept, load, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // done marks the edge where the frame's last bit is sampled; word is what would be stored then
  always_comb begin
    nxt      = state;
    done     = 1'b0;
    word     = shift_reg;
    perr_now = 1'b0;
    case (state)
      IDLE: if (shift_en && serial_in) nxt = DATA;
      DATA: if (shift_en && cnt == LAST) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
        nxt = PARITY;
`else
        nxt  = IDLE;
        done = 1'b1;
        word = {shift_reg[WIDTH-2:0], serial_in};
`endif
      end
`ifdef SIPO_DEFRAMER_PARITY_EN
      PARITY: if (shift_en) begin
        nxt      = IDLE;
        done     = 1'b1;
        perr_now = ^{shift_reg, serial_in};
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign accept = data_valid & data_ready;
  // a full holding register still takes the new word if it is being consumed on the same edge
  assign load   = done & (~data_valid | data_ready);
  assign drop   = done & ~load;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (shift_en) begin
        if (state == IDLE && serial_in) begin
          cnt <= '0;
        end else if (state == DATA) begin
          shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
          cnt       <= cnt + 1'b1;
        end
      end
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (accept) begin
        data_valid <= 1'b0;
      end
      if (accept)    overrun <= 1'b0;
      else if (drop) overrun <= 1'b1;
    end
  end

`ifdef SIPO_DEFRAMER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    parity_err <= 1'b0;
    else if (load) parity_err <= perr_now;
  end
`endif

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
- Downstream consumer of the 4-bit parallel-to-serial shifter's serial output.
- Detects a start bit, then shifts in WIDTH data bits MSB-first.
- Presents each assembled word on a valid/ready parallel interface backed by a one-word holding register.
- Flags overrun when a completed word cannot be stored.

Parameters:
WIDTH, 4, data bits per frame (≥2); matches the upstream shifter word size.

Ports:
clk  input  1  rising-edge clock, shared with the upstream shifter
rst_n  input  1  asynchronous active-low reset
serial_in  input  1  serial bit stream, MSB first
shift_en  input  1  sample enable; serial_in is sampled only on edges where shift_en=1
data_out  output  WIDTH  assembled word (holding register)
data_valid  output  1  holding register contains an unconsumed word
data_ready  input  1  consumer accepts data_out on an edge where data_valid=1 and data_ready=1
busy  output  1  frame reception in progress (state ≠ IDLE)
overrun  output  1  sticky: a completed word was dropped
parity_err  output  1  present only with PARITY_EN; see Optional Feature

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; shift register, bit counter and data_out = 0.
  - data_valid=0, busy=0, overrun=0, parity_err=0.
  - Reset mid-frame discards the partial word.
- shift_en=0: state, counter and shift register hold. The output handshake still operates.
- States: IDLE, DATA, (PARITY only with PARITY_EN), then back to IDLE.
- IDLE:
  - On an edge with shift_en=1 and serial_in=1 (start bit), go to DATA and set the counter to 0.
  - serial_in=0 stays in IDLE (idle line = 0).
- DATA:
  - Each enabled edge: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}; counter++.
  - The first data bit sampled is the edge after the start bit.
  - On the edge sampling bit WIDTH-1 (counter = WIDTH-1), the word is complete.
  - Without PARITY_EN, the word completes on that same edge and the state goes to IDLE.
- Word completion, evaluated at that edge:
  - If data_valid=0, or data_valid=1 with data_ready=1 on the same edge (simultaneous consume): load data_out with the completed word and set data_valid=1. No overrun.
  - Otherwise: the new word is dropped, data_out is unchanged, and overrun<=1.
- Latency: data_valid rises on the edge that samples the last data bit. Start bit to data_valid = WIDTH+1 enabled edges.
- Handshake:
  - When data_valid=1 and data_ready=1, data_valid clears on the next edge unless a new word loads on that edge.
  - data_out is stable while data_valid=1 and not accepted.
- overrun:
  - Sticky; cleared on an edge where a handshake completes (data_valid & data_ready).
  - Overrun set in the same edge as a clearing handshake cannot occur, because the simultaneous consume rule wins.
- Back-to-back frames: a start bit may be sampled on the first enabled edge after returning to IDLE.
- busy = (state ≠ IDLE), registered with state.

Optional Feature:
- Macro: SIPO_DEFRAMER_PARITY_EN.
- Defined:
  - After the last data bit, the state goes to PARITY; the next enabled edge samples an even-parity bit (XOR of data bits and parity bit must be 0).
  - Word completion and all handshake/overrun rules apply on the parity edge instead of the last data edge.
  - parity_err loads the check result along with data_out and is valid while data_valid=1.
  - Start-to-valid latency = WIDTH+2 enabled edges.
- Undefined: no PARITY state and no parity_err port; a frame is start + WIDTH bits.

Test Plan:
- Reset mid-frame: start=1, bits 1,0, assert rst_n=0 -> busy=0, data_valid=0, data_out=0 immediately. Next frame 1,0110 -> data_out=4'b0110.
- Single frame: shift_en=1, serial_in sequence 1,1,0,1,1, data_ready=1 -> data_valid=1 for one cycle with data_out=4'b1011, asserted on the 5th edge, busy 1 for 4 edges.
- shift_en gaps: frame 1,1,0,0,1 with shift_en=0 for 3 cycles between every bit -> data_out=4'b1001; state/counter frozen during gaps.
- Back-pressure/overrun: data_ready=0, frames 1011 then 0101 -> data_out stays 4'b1011, overrun=1. Raise data_ready -> handshake, data_valid=0, overrun=0.
- Simultaneous consume: data_valid=1 (0011), data_ready=1 on the edge the next frame 1110 completes -> data_out=4'b1110, data_valid stays 1, overrun=0.
- PARITY_EN: frame 1,1011,1 -> parity_err=0. Frame 1,1011,0 -> parity_err=1, data_out=4'b1011, valid on the 6th edge.
